alu_cmd_sequencer: RTL and testbench

Sequences commands into the shared ALU datapath. Each command is a 10-bit operand plus a one-hot 6-bit opcode. Commands are buffered in a small FIFO and presented to the ALU one at a time. Each command is held on the ALU/display inputs for a programmable dwell time (auto mode) or until a step pulse (manual mode). Sits between the board-input capture logic and the ALU top.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 59 +++++
 rtl/alu_cmd_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned OPERAND_W = 10;
    localparam int unsigned OPCODE_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ADD    = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_MUL    = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_FSB    = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_SHIFT  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_MEDIAN = 6'b010000;
    localparam logic [OPCODE_W-1:0] OP_PASS   = 6'b100000;

    typedef struct packed {
        logic [OPERAND_W-1:0] operand;
        logic [OPCODE_W-1:0]  opcode;
    } cmd_t;

    // A legal opcode has exactly one bit set.
    function automatic logic opcode_valid(input logic [OPCODE_W-1:0] op);
        return $countones(op) == 1;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO with flush; head is read combinationally.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     wdata,
    input  logic                     pop,
    input  logic                     flush,
    output cmd_t                     head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c && !flush;
    assign do_pop  = pop && !empty_c && !flush;
    assign head_c  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers commands and presents them to the ALU for a dwell time or until step.
// Optional opcode legality check enabled by defining ALU_SEQ_OPCHECK_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DWELL   = 25000000,
    parameter int unsigned DWELL_W = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPERAND_W-1:0]    cmd_operand,
    input  logic [OPCODE_W-1:0]     cmd_opcode,
    input  logic                    auto_mode,
    input  logic                    step,
    input  logic                    flush,
    output logic [OPERAND_W-1:0]    alu_operand,
    output logic [OPCODE_W-1:0]     alu_opcode,
    output logic                    alu_valid,
    output logic                    done_pulse,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    err
);

    state_t               state, state_nxt;
    logic [DWELL_W-1:0]   cnt, cnt_nxt;
    logic                 valid_nxt;
    logic                 done_nxt;
    logic                 load;
    logic                 advance;
    logic                 push_hs;
    logic                 opcode_ok;
    logic                 full_c;
    logic                 empty_c;
    cmd_t                 head_c;
    cmd_t                 wdata;

    assign cmd_ready = !full_c;
    assign push_hs   = cmd_valid && cmd_ready && !flush;
    assign wdata     = '{operand: cmd_operand, opcode: cmd_opcode};

`ifdef ALU_SEQ_OPCHECK_EN
    assign opcode_ok = opcode_valid(cmd_opcode);

    // Sticky until flush or reset; a bad command is consumed but never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      err <= 1'b0;
        else if (flush)                  err <= 1'b0;
        else if (push_hs && !opcode_ok)  err <= 1'b1;
    end
`else
    assign opcode_ok = 1'b1;
    assign err       = 1'b0;
`endif

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_hs && opcode_ok),
        .wdata   (wdata),
        .pop     (load),
        .flush   (flush),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_valid  <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            alu_valid  <= valid_nxt;
            done_pulse <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = alu_valid;
        done_nxt  = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;

        case (state)
            IDLE: begin
                if (!empty_c) load = 1'b1;
            end
            SHOW: begin
                // Manual mode freezes the counter so a later switch to auto resumes it.
                if (auto_mode) begin
                    if (cnt == '0) advance = 1'b1;
                    else           cnt_nxt = cnt - DWELL_W'(1);
                end else if (step) begin
                    advance = 1'b1;
                end
                if (advance) begin
                    done_nxt = 1'b1;
                    if (!empty_c) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt = SHOW;
            valid_nxt = 1'b1;
            cnt_nxt   = DWELL_W'(DWELL - 1);
        end

        if (flush) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            done_nxt  = 1'b0;
            cnt_nxt   = '0;
            load      = 1'b0;
        end
    end

    // Display registers hold their value while idle or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_operand <= '0;
            alu_opcode  <= '0;
        end else if (load) begin
            alu_operand <= head_c.operand;
            alu_opcode  <= head_c.opcode;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: stimulus table, directed corner sequences, random run vs queue model.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DWELL   = 3;
    localparam int unsigned DWELL_W = 4;
`ifdef ALU_SEQ_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [OPERAND_W-1:0]   cmd_operand;
    logic [OPCODE_W-1:0]    cmd_opcode;
    logic                   auto_mode;
    logic                   step;
    logic                   flush;
    logic [OPERAND_W-1:0]   alu_operand;
    logic [OPCODE_W-1:0]    alu_opcode;
    logic                   alu_valid;
    logic                   done_pulse;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   err;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .DWELL(DWELL), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_operand(cmd_operand), .cmd_opcode(cmd_opcode), .auto_mode(auto_mode),
        .step(step), .flush(flush), .alu_operand(alu_operand), .alu_opcode(alu_opcode),
        .alu_valid(alu_valid), .done_pulse(done_pulse), .fifo_count(fifo_count), .err(err)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: a queue of pending commands plus "cycles left to show".
    cmd_t                 mq[$];
    bit                   m_show;
    int                   m_left;
    bit                   m_done;
    bit                   m_err;
    logic [OPERAND_W-1:0] m_op;
    logic [OPCODE_W-1:0]  m_opc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_show = 1'b0; m_left = 0; m_done = 1'b0; m_err = 1'b0;
        m_op = '0; m_opc = '0;
    endtask

    task automatic model_step(input bit v, input logic [OPERAND_W-1:0] od,
                              input logic [OPCODE_W-1:0] oc, input bit am,
                              input bit st, input bit fl);
        bit   rdy, ok, adv, nonempty;
        cmd_t hd;
        rdy      = (mq.size() < DEPTH);
        ok       = !OPCHK || ($countones(oc) == 1);
        nonempty = (mq.size() > 0);
        if (fl) begin
            mq.delete();
            m_show = 1'b0; m_done = 1'b0; m_err = 1'b0;
            return;
        end
        adv    = m_show && (am ? (m_left == 1) : st);
        m_done = adv;
        if (nonempty && (!m_show || adv)) begin
            hd = mq.pop_front();
            m_op = hd.operand; m_opc = hd.opcode;
            m_show = 1'b1; m_left = DWELL;
        end else if (adv) begin
            m_show = 1'b0;
        end else if (m_show && am) begin
            m_left--;
        end
        if (v && rdy) begin
            if (ok) mq.push_back('{operand: od, opcode: oc});
            else    m_err = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("valid",  alu_valid,   m_show);
        chk("operand", alu_operand, m_op);
        chk("opcode", alu_opcode,  m_opc);
        chk("done",   done_pulse,  m_done);
        chk("count",  fifo_count,  mq.size());
        chk("ready",  cmd_ready,   mq.size() < DEPTH);
        chk("err",    err,         m_err);
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later.
    task automatic cycle(input bit v, input logic [OPERAND_W-1:0] od,
                         input logic [OPCODE_W-1:0] oc, input bit am,
                         input bit st, input bit fl);
        cmd_valid = v; cmd_operand = od; cmd_opcode = oc;
        auto_mode = am; step = st; flush = fl;
        @(posedge clk);
        model_step(v, od, oc, am, st, fl);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit am);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, am, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_operand = '0; cmd_opcode = '0;
        auto_mode = 1'b1; step = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", alu_valid, 0);
        chk("rst_operand", alu_operand, 0);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit                   v;
        logic [OPERAND_W-1:0] od;
        logic [OPCODE_W-1:0]  oc;
        bit                   am;
        bit                   st;
        bit                   fl;
        bit                   e_valid;
        logic [OPERAND_W-1:0] e_op;
        bit                   e_done;
        int                   e_cnt;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   accepted, vcnt, first_v, last_v, k;
        logic [OPCODE_W-1:0] roc;
        bit   ram;

        rst_n = 1'b0;
        model_reset();
        tbl[0] = '{1, 10'h155, OP_ADD, 1, 0, 0, 0, 10'h000, 0, 1};
        tbl[1] = '{0, 10'h000, 6'h00,  1, 0, 0, 1, 10'h155, 0, 0};
        tbl[2] = '{0, 10'h000, 6'h00,  1, 0, 0, 1, 10'h155, 0, 0};
        tbl[3] = '{0, 10'h000, 6'h00,  1, 0, 0, 1, 10'h155, 0, 0};
        tbl[4] = '{0, 10'h000, 6'h00,  1, 0, 0, 0, 10'h155, 1, 0};
        tbl[5] = '{0, 10'h000, 6'h00,  1, 0, 0, 0, 10'h155, 0, 0};

        // Single command, auto mode: three-cycle dwell then idle with display held.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].v, tbl[i].od, tbl[i].oc, tbl[i].am, tbl[i].st, tbl[i].fl);
            chk($sformatf("t1_valid[%0d]", i), alu_valid, tbl[i].e_valid);
            chk($sformatf("t1_operand[%0d]", i), alu_operand, tbl[i].e_op);
            chk($sformatf("t1_done[%0d]", i), done_pulse, tbl[i].e_done);
            chk($sformatf("t1_count[%0d]", i), fifo_count, tbl[i].e_cnt);
        end

        // Five commands with cmd_valid held high: shown back-to-back for 5*DWELL cycles.
        do_reset();
        accepted = 0; vcnt = 0; first_v = -1; last_v = -1; k = 0;
        while (k < 40) begin
            bit rdy_pre;
            rdy_pre = cmd_ready;
            cycle(accepted < 5, 10'(16 + accepted), OP_MUL, 1'b1, 1'b0, 1'b0);
            if (accepted < 5 && rdy_pre) accepted++;
            if (alu_valid) begin
                vcnt++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            k++;
        end
        chk("t2_accepted", accepted, 5);
        chk("t2_valid_cycles", vcnt, 5 * DWELL);
        chk("t2_contiguous", last_v - first_v + 1, 5 * DWELL);

        // Manual mode: fill to full, ready drops, a step frees a slot.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 10'(32 + i), OP_FSB, 1'b0, 1'b0, 1'b0);
        chk("t2m_full_count", fifo_count, 4);
        chk("t2m_ready_low", cmd_ready, 0);
        idle(20, 1'b0);
        chk("t3_held_valid", alu_valid, 1);
        chk("t3_held_operand", alu_operand, 10'd32);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("t3_step_operand", alu_operand, 10'd33);
        chk("t3_step_done", done_pulse, 1);
        chk("t3_ready_back", cmd_ready, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("t3_idle_valid", alu_valid, 0);
        chk("t3_idle_count", fifo_count, 0);
        chk("t3_idle_operand", alu_operand, 10'd36);

        // Flush during SHOW alongside a push discards everything.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 10'(64 + i), OP_SHIFT, 1'b0, 1'b0, 1'b0);
        chk("t4_pre_count", fifo_count, 3);
        cycle(1'b1, 10'h3FF, OP_PASS, 1'b0, 1'b1, 1'b1);
        chk("t4_count", fifo_count, 0);
        chk("t4_valid", alu_valid, 0);
        chk("t4_done", done_pulse, 0);
        chk("t4_operand_held", alu_operand, 10'd64);
        idle(3, 1'b0);
        chk("t4_stays_idle", alu_valid, 0);

        // Illegal opcode followed by a legal one.
        do_reset();
        cycle(1'b1, 10'h0AA, 6'b000011, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 10'h0BB, 6'b000100, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("t5_err", err, OPCHK);
        chk("t5_shown", alu_operand, OPCHK ? 10'h0BB : 10'h0AA);
        idle(10, 1'b1);
        chk("t5_err_sticky", err, OPCHK);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("t5_err_cleared", err, 0);

        // Async reset mid-SHOW with two queued.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 10'(80 + i), OP_MEDIAN, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_valid", alu_valid, 1);
        chk("t6_pre_count", fifo_count, 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", alu_valid, 0);
        chk("t6_operand", alu_operand, 0);
        chk("t6_done", done_pulse, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised run against the model, including mid-SHOW mode switches.
        do_reset();
        ram = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) ram = !ram;
            if ($urandom_range(0, 4) == 0) roc = 6'($urandom);
            else                           roc = 6'(1 << $urandom_range(0, 5));
            cycle($urandom_range(0, 1) == 1, 10'($urandom), roc, ram,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
